// File: rtl/mem_port_arbiter.sv
`default_nettype none
// mem_port_arbiter: same-cycle grant of committed stores and issued loads onto registered dcache ports. Rev 1.0
// Optional MEM_ARB_PERF_CNT_EN adds 32-bit grant/escalation performance counters.
module mem_port_arbiter #(
  parameter int NUM_ST       = 2,
  parameter int NUM_LD       = 2,
  parameter int NUM_PORTS    = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4,
  parameter int MEM_FUNC_W   = 3,
  parameter int LQ_IDX_W     = 4
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  squash,
  input  logic [NUM_ST-1:0]                     st_valid,
  input  logic [NUM_ST-1:0][31:0]               st_addr,
  input  logic [NUM_ST-1:0][31:0]               st_data,
  input  logic [NUM_ST-1:0][MEM_FUNC_W-1:0]     st_func,
  output logic [NUM_ST-1:0]                     st_accept,
  input  logic [NUM_LD-1:0]                     ld_valid,
  input  logic [NUM_LD-1:0][31:0]               ld_addr,
  input  logic [NUM_LD-1:0][MEM_FUNC_W-1:0]     ld_func,
  input  logic [NUM_LD-1:0][LQ_IDX_W-1:0]       ld_tag,
  output logic [NUM_LD-1:0]                     ld_accept,
  output logic [NUM_PORTS-1:0]                  port_valid,
  output logic [NUM_PORTS-1:0]                  port_is_store,
  output logic [NUM_PORTS-1:0][31:0]            port_addr,
  output logic [NUM_PORTS-1:0][31:0]            port_data,
  output logic [NUM_PORTS-1:0][MEM_FUNC_W-1:0]  port_func,
  output logic [NUM_PORTS-1:0][LQ_IDX_W-1:0]    port_tag,
  input  logic [NUM_PORTS-1:0]                  port_stall
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]                           perf_st_grants,
  output logic [31:0]                           perf_ld_grants,
  output logic [31:0]                           perf_escalations
`endif
);

  localparam int LD_W  = (NUM_LD > 1) ? $clog2(NUM_LD) : 1;
  localparam int SRC_N = (NUM_ST > NUM_LD) ? NUM_ST : NUM_LD;
  localparam int SRC_W = (SRC_N > 1) ? $clog2(SRC_N) : 1;

  logic [LD_W-1:0]                      r_rr_ld;
  logic [CNT_W-1:0]                     r_st_starve;
  logic [CNT_W-1:0]                     r_ld_starve;
  logic [NUM_PORTS-1:0]                 r_port_valid;
  logic [NUM_PORTS-1:0]                 r_port_is_store;
  logic [NUM_PORTS-1:0][31:0]           r_port_addr;
  logic [NUM_PORTS-1:0][31:0]           r_port_data;
  logic [NUM_PORTS-1:0][MEM_FUNC_W-1:0] r_port_func;
  logic [NUM_PORTS-1:0][LQ_IDX_W-1:0]   r_port_tag;

  logic [NUM_PORTS-1:0]                 w_port_free;
  logic [NUM_PORTS-1:0]                 w_avail;
  logic [NUM_PORTS-1:0]                 w_port_take;
  logic [NUM_PORTS-1:0]                 w_port_take_st;
  logic [NUM_PORTS-1:0][SRC_W-1:0]      w_port_src;
  logic [NUM_ST-1:0]                    w_st_acc;
  logic [NUM_LD-1:0]                    w_ld_acc;
  logic [LD_W-1:0]                      w_rr_next;
  logic [LD_W-1:0]                      w_idx;
  logic                                 w_st_prio;
  logic                                 w_st_en;
  logic                                 w_ld_en;
  logic                                 w_st_blocked;
  logic                                 w_found;

  // A stalled, occupied port keeps its request; everything else may be refilled.
  assign w_port_free = ~r_port_valid | ~port_stall;
  assign w_st_prio   = (r_st_starve == CNT_W'(STARVE_LIMIT));
  assign w_st_en     = ~reset;
  assign w_ld_en     = ~reset & ~squash;

  always_comb begin
    w_avail        = w_port_free;
    w_port_take    = '0;
    w_port_take_st = '0;
    w_port_src     = '0;
    w_st_acc       = '0;
    w_ld_acc       = '0;
    w_rr_next      = r_rr_ld;
    w_idx          = '0;
    w_st_blocked   = 1'b0;
    w_found        = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      if ((pass == 0) == w_st_prio) begin
        // Stores stop at the first slot that cannot go, keeping the grant mask contiguous.
        for (int i = 0; i < NUM_ST; i++) begin
          if (w_st_en && !w_st_blocked && st_valid[i] && (|w_avail)) begin
            w_found     = 1'b0;
            w_st_acc[i] = 1'b1;
            for (int p = 0; p < NUM_PORTS; p++) begin
              if (!w_found && w_avail[p]) begin
                w_found           = 1'b1;
                w_avail[p]        = 1'b0;
                w_port_take[p]    = 1'b1;
                w_port_take_st[p] = 1'b1;
                w_port_src[p]     = SRC_W'(i);
              end
            end
          end else begin
            w_st_blocked = 1'b1;
          end
        end
      end else begin
        for (int k = 0; k < NUM_LD; k++) begin
          w_idx = LD_W'((int'(r_rr_ld) + k) % NUM_LD);
          if (w_ld_en && ld_valid[w_idx] && (|w_avail)) begin
            w_found         = 1'b0;
            w_ld_acc[w_idx] = 1'b1;
            w_rr_next       = LD_W'((int'(w_idx) + 1) % NUM_LD);
            for (int p = 0; p < NUM_PORTS; p++) begin
              if (!w_found && w_avail[p]) begin
                w_found        = 1'b1;
                w_avail[p]     = 1'b0;
                w_port_take[p] = 1'b1;
                w_port_src[p]  = SRC_W'(w_idx);
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_port_valid    <= '0;
      r_port_is_store <= '0;
      r_port_addr     <= '0;
      r_port_data     <= '0;
      r_port_func     <= '0;
      r_port_tag      <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (w_port_take[p]) begin
          r_port_valid[p]    <= 1'b1;
          r_port_is_store[p] <= w_port_take_st[p];
          if (w_port_take_st[p]) begin
            r_port_addr[p] <= st_addr[w_port_src[p]];
            r_port_data[p] <= st_data[w_port_src[p]];
            r_port_func[p] <= st_func[w_port_src[p]];
            r_port_tag[p]  <= '0;
          end else begin
            r_port_addr[p] <= ld_addr[w_port_src[p]];
            r_port_data[p] <= '0;
            r_port_func[p] <= ld_func[w_port_src[p]];
            r_port_tag[p]  <= ld_tag[w_port_src[p]];
          end
        end else if (w_port_free[p] || (squash && !r_port_is_store[p])) begin
          r_port_valid[p] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rr_ld     <= '0;
      r_st_starve <= '0;
      r_ld_starve <= '0;
    end else begin
      r_rr_ld <= squash ? '0 : w_rr_next;
      if (!(|st_valid) || (|w_st_acc)) begin
        r_st_starve <= '0;
      end else if (r_st_starve < CNT_W'(STARVE_LIMIT)) begin
        r_st_starve <= r_st_starve + 1'b1;
      end
      if (squash || !(|ld_valid) || (|w_ld_acc)) begin
        r_ld_starve <= '0;
      end else if (r_ld_starve < CNT_W'(STARVE_LIMIT)) begin
        r_ld_starve <= r_ld_starve + 1'b1;
      end
    end
  end

`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] r_perf_st;
  logic [31:0] r_perf_ld;
  logic [31:0] r_perf_esc;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_perf_st  <= '0;
      r_perf_ld  <= '0;
      r_perf_esc <= '0;
    end else begin
      r_perf_st  <= r_perf_st + 32'($countones(w_st_acc));
      r_perf_ld  <= r_perf_ld + 32'($countones(w_ld_acc));
      r_perf_esc <= r_perf_esc + {31'd0, w_st_prio};
    end
  end

  assign perf_st_grants   = r_perf_st;
  assign perf_ld_grants   = r_perf_ld;
  assign perf_escalations = r_perf_esc;
`endif

  assign st_accept     = w_st_acc;
  assign ld_accept     = w_ld_acc;
  assign port_valid    = r_port_valid;
  assign port_is_store = r_port_is_store;
  assign port_addr     = r_port_addr;
  assign port_data     = r_port_data;
  assign port_func     = r_port_func;
  assign port_tag      = r_port_tag;

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the data-cache request ports between committed stores leaving the store queue and issued loads from the load FUs.
- Grants are made in the same cycle the request is presented. Granted requests are registered into per-port output slots, so the dcache sees them one cycle later.
- Store order is preserved: SQ slot i is granted only if every lower slot that is valid is also granted.
- Starvation of either class is bounded by an escalation counter.

Parameters:
- NUM_ST, 2, store request slots (matches `NUM_SQ_DCACHE)
- NUM_LD, 2, load request slots (matches `NUM_FU_LOAD)
- NUM_PORTS, 2, dcache request ports
- STARVE_LIMIT, 4, consecutive cycles a class may be denied while it has a valid request before it gets priority
- CNT_W, 4, width of starvation counters; must satisfy STARVE_LIMIT < 2^CNT_W

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- squash  in  1  pipeline flush from ROB
- st_valid  in  NUM_ST  store request valid, slot 0 = oldest
- st_addr  in  NUM_ST x 32  store address
- st_data  in  NUM_ST x 32  store data
- st_func  in  NUM_ST x MEM_FUNC  store size/sign
- st_accept  out  NUM_ST  store granted this cycle (combinational)
- ld_valid  in  NUM_LD  load request valid
- ld_addr  in  NUM_LD x 32  load address
- ld_func  in  NUM_LD x MEM_FUNC  load size/sign
- ld_tag  in  NUM_LD x LQ_IDX  load queue index, returned with the grant
- ld_accept  out  NUM_LD  load granted this cycle (combinational)
- port_valid  out  NUM_PORTS  registered request valid to dcache
- port_is_store  out  NUM_PORTS  1 = store, 0 = load
- port_addr  out  NUM_PORTS x 32  registered address
- port_data  out  NUM_PORTS x 32  registered store data; 0 for loads
- port_func  out  NUM_PORTS x MEM_FUNC  registered size/sign
- port_tag  out  NUM_PORTS x LQ_IDX  load tag; 0 for stores
- port_stall  in  NUM_PORTS  dcache cannot take this port's request this cycle

Behaviour:
- Port availability:
  - Port p is free when port_valid[p]=0, or when port_valid[p]=1 and port_stall[p]=0.
  - A stalled port holds all of its registered fields unchanged.
- Grant order:
  - Free ports are filled lowest index first.
  - Default priority: loads first, then stores.
  - Priority flips to stores first when st_starve == STARVE_LIMIT.
  - If both counters are at the limit, stores win; the load counter stays saturated and wins the following cycle.
- Loads:
  - Granted round-robin starting at pointer rr_ld.
  - rr_ld advances to one past the last granted load index, mod NUM_LD.
  - rr_ld holds if no load is granted.
- Stores:
  - Granted in slot order only. Stop at the first valid, ungranted slot.
  - st_accept must always be a contiguous low-order mask.
- Starvation counters (st_starve, ld_starve):
  - Increment when the class has any valid request and receives zero grants.
  - Reset to 0 when the class receives at least one grant, or has no valid request.
  - Saturate at STARVE_LIMIT.
- Latency:
  - Accept in cycle t means port_valid=1 with that payload in cycle t+1.
  - No request is ever granted to two ports, and none is dropped once accepted.
- Widths: addr and data pass through unmodified; no realignment in this block.
- Squash:
  - Same cycle: ld_accept forced to 0.
  - Next edge: any registered load slot is cleared (port_valid <= 0) even if stalled.
  - Store grants and registered stores are unaffected, because they are already committed.
  - rr_ld and ld_starve reset to 0.
- Reset:
  - All port_* registers, rr_ld, st_starve and ld_starve go to 0.
  - st_accept and ld_accept are 0 while reset is high.
  - Reset mid-stall discards the held request.
- Boundary cases:
  - All ports stalled: no accepts; counters still update.
  - NUM_PORTS > total requests: unused ports load port_valid=0.

Optional Feature:
- Macro: MEM_ARB_PERF_CNT_EN.
- When defined:
  - Adds outputs perf_st_grants, perf_ld_grants and perf_escalations, each 32 bits.
  - Each counts per clock: number of store grants, number of load grants, and cycles where store-priority escalation was active.
  - Counters clear on reset only and wrap on overflow.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Loads and stores contend. Stimulus: NUM_PORTS=2; ld_valid=2'b11 and st_valid=2'b11, held every cycle. Required response:
  - Cycles 1-4: ld_accept=11, st_accept=00.
  - Cycle 5 (st_starve=4): st_accept=11, ld_accept=00.
  - Cycle 6: loads are granted again.
- Store ordering: st_valid=11, ld_valid=01, no escalation -> port0=load, st_accept=01 (slot0 only), never 10.
- Port stall: port_stall[0]=1 for 3 cycles with port0 holding store A (addr 0x100) -> port0 holds A for all 3 cycles; new requests use port1 only; A is released on the cycle after the stall drops.
- Squash: port0=load tag 5 stalled, port1=store addr 0x200 stalled, squash=1 -> next cycle port0 valid=0; port1 still holds addr 0x200.
- Round-robin: only ld_valid=11, NUM_PORTS=1 -> grants alternate slot0, slot1, slot0...; rr_ld reads 0 after reset and after squash.
- Reset mid-operation: reset during active grants -> next cycle all port_valid=0, counters 0, and accepts are 0 while reset is high.
